game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Game-flow sequencer for the dodge game. It sits between keyboard decode, the collision detector and the VGA frame strobe, and owns the play/hit/game-over sequencing. It gates the character and enemy drivers, runs the survival timer as BCD digits for the 7-segment driver, and drives the red-flash background overlay. All logic runs on CLK100MHZ; the pixel-domain inputs are synchronised internally.

## Interface
Parameters:
- FRAMES_PER_SEC, 60, frame ticks per timer second
- FLASH_FRAMES, 30, frames spent in FLASH before OVER (1..255)
- SYNC_STAGES, 2, synchroniser depth for vsync_in/hit_in (≥2)

Ports:
- CLK100MHZ  in  1  system clock
- CPU_RESETN  in  1  reset, asynchronous, active-low
- vsync_in  in  1  raw VGA vertical sync from the pixel domain, asynchronous to CLK100MHZ
- hit_in  in  1  collision flag from the pixel domain, level, asynchronous
- move_req  in  1  OR of held arrow keys, CLK100MHZ domain
- restart_req  in  1  single-cycle pulse from the restart key, CLK100MHZ domain
- char_en  out  1  character driver enable
- enemy_en  out  1  enemy driver enable
- flash_red  out  1  red background overlay
- state  out  2  0=IDLE 1=RUN 2=FLASH 3=OVER
- frame_tick  out  1  one-cycle pulse per frame
- dig_sec, dig_tens, dig_hund  out  4 each  BCD timer digits

## Operation
- Synchronisers: vsync_in and hit_in each pass through SYNC_STAGES flops. frame_tick = rising edge of synced vsync (flop plus edge detect).
- Frame counter fc: 0..FRAMES_PER_SEC-1. Advances only in RUN, on frame_tick. On wrap to 0, the BCD timer increments.
- BCD timer: dig_sec 9→0 carries into dig_tens; dig_tens 9→0 carries into dig_hund. Saturates at 9/9/9, with no wrap to 000.
- IDLE: char_en=1, enemy_en=0, flash_red=0. Timer and fc are held at 0. move_req=1 → RUN. hit ignored.
- RUN: char_en=1, enemy_en=1, flash_red=0. Timer runs. Synced hit=1 → FLASH; flash counter fl loads 0.
- FLASH: char_en=0, enemy_en=0. flash_red toggles on every 4th frame_tick, starting at 1 on entry. fl increments per frame_tick. On the tick where fl reaches FLASH_FRAMES-1 → OVER. Timer is frozen.
- OVER: char_en=0, enemy_en=0, flash_red=1 steady. Timer holds its final value. restart_req → IDLE, clearing timer, fc and fl.
- restart_req is ignored in IDLE, RUN and FLASH. move_req is ignored outside IDLE.
- Simultaneous events:
  - RUN with hit and frame_tick in the same cycle: the tick is counted, including any carry, and the state moves to FLASH.
  - OVER with restart_req and move_req together: the state goes to IDLE. The move is acted on from the next cycle, so RUN follows one cycle later if move_req is still high.
- Reset, async, at any time: state=IDLE, char_en=1, enemy_en=0, flash_red=0, frame_tick=0, all digits 0, all internal counters and synchronisers 0. Asserting reset mid-FLASH or mid-count is legal and takes effect immediately.

## Timing
- All outputs are registered, and change only on a CLK100MHZ rising edge or on async reset.
- hit_in→enemy_en: a hit stable before edge k is in the last synchroniser stage at edge k+SYNC_STAGES-1. State and outputs update at edge k+SYNC_STAGES (3 edges at the default depth).
- vsync_in rise→frame_tick: the pulse is high for exactly one cycle, starting SYNC_STAGES+1 edges after the rise.
- frame_tick→digit update: digits change on the same edge that consumes the tick, 1 cycle after frame_tick is visible.
- move_req→RUN: 1 edge. restart_req→IDLE: 1 edge.
- A minimum of 2 CLK100MHZ cycles between frame_ticks is guaranteed by the VGA period and needs no handling.

## Test plan
- Reset mid-RUN with timer at 0/1/2: assert CPU_RESETN=0 asynchronously → outputs are immediately state=0, enemy_en=0, char_en=1, digits 0/0/0.
- Normal count: move_req=1 for 1 cycle, then 125 vsync pulses → state=1 after 1 edge. After 60 ticks dig_sec=1; after 120 ticks dig_sec=2. enemy_en stays 1.
- Carry and saturation: preload via 59,999 ticks → digits 9/9/9. 60 more ticks → still 9/9/9. Separately, the 599→600 tick boundary → dig_tens=1, dig_sec=0.
- Hit sequence: in RUN assert hit_in → enemy_en=0 and state=2 within 3 edges. flash_red toggles every 4 ticks. After 30 ticks, state=3 and flash_red=1. Digits are frozen from the moment of the hit.
- Simultaneous events: a hit coincident with the tick that completes second 4 → dig_sec=4 and state=2. In OVER, restart_req and move_req high together → state=0 next edge, state=1 the edge after, digits 0.
- Ignore rules: restart_req in RUN → no change. hit_in in IDLE or OVER → no change. Toggling move_req in FLASH → no change.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer for the dodge game: IDLE -> RUN -> FLASH -> OVER, with the
// survival timer kept as saturating BCD digits and the pixel-domain inputs synchronised.
module game_flow_ctrl #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int FLASH_FRAMES   = 30,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       vsync_in,
  input  logic       hit_in,
  input  logic       move_req,
  input  logic       restart_req,
  output logic       char_en,
  output logic       enemy_en,
  output logic       flash_red,
  output logic [1:0] state,
  output logic       frame_tick,
  output logic [3:0] dig_sec,
  output logic [3:0] dig_tens,
  output logic [3:0] dig_hund
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLASH = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam int FC_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

  logic [SYNC_STAGES-1:0] vsync_sync_q;
  logic [SYNC_STAGES-1:0] hit_sync_q;
  logic                   vsync_prev_q;
  logic                   frame_tick_q;
  logic                   vsync_s;
  logic                   hit_s;

  assign vsync_s = vsync_sync_q[SYNC_STAGES-1];
  assign hit_s   = hit_sync_q[SYNC_STAGES-1];

  // Bit 0 is the first synchroniser stage; the top bit is the safe one to use.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      vsync_sync_q <= '0;
      hit_sync_q   <= '0;
      vsync_prev_q <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      vsync_sync_q <= {vsync_sync_q[SYNC_STAGES-2:0], vsync_in};
      hit_sync_q   <= {hit_sync_q[SYNC_STAGES-2:0], hit_in};
      vsync_prev_q <= vsync_s;
      frame_tick_q <= vsync_s & ~vsync_prev_q;
    end
  end

  state_t            state_q, state_d;
  logic [FC_W-1:0]   fc_q, fc_d;
  logic [7:0]        fl_q, fl_d;
  logic [3:0]        sec_q, sec_d, tens_q, tens_d, hund_q, hund_d;
  logic [3:0]        sec_inc, tens_inc, hund_inc;
  logic              flash_q, flash_d;
  logic              char_en_q, char_en_d;
  logic              enemy_en_q, enemy_en_d;

  // One-second increment of the BCD timer, holding at 999.
  always_comb begin
    sec_inc  = sec_q;
    tens_inc = tens_q;
    hund_inc = hund_q;
    if (!(hund_q == 4'd9 && tens_q == 4'd9 && sec_q == 4'd9)) begin
      if (sec_q == 4'd9) begin
        sec_inc = 4'd0;
        if (tens_q == 4'd9) begin
          tens_inc = 4'd0;
          hund_inc = hund_q + 4'd1;
        end else begin
          tens_inc = tens_q + 4'd1;
        end
      end else begin
        sec_inc = sec_q + 4'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    fl_d    = fl_q;
    sec_d   = sec_q;
    tens_d  = tens_q;
    hund_d  = hund_q;
    flash_d = flash_q;
    case (state_q)
      ST_IDLE: begin
        fc_d    = '0;
        fl_d    = '0;
        sec_d   = 4'd0;
        tens_d  = 4'd0;
        hund_d  = 4'd0;
        flash_d = 1'b0;
        if (move_req) state_d = ST_RUN;
      end
      ST_RUN: begin
        // A tick arriving with the hit is still counted before freezing.
        if (frame_tick_q) begin
          if (fc_q == FC_W'(FRAMES_PER_SEC - 1)) begin
            fc_d   = '0;
            sec_d  = sec_inc;
            tens_d = tens_inc;
            hund_d = hund_inc;
          end else begin
            fc_d = fc_q + 1'b1;
          end
        end
        if (hit_s) begin
          state_d = ST_FLASH;
          fl_d    = '0;
          flash_d = 1'b1;
        end
      end
      ST_FLASH: begin
        if (frame_tick_q) begin
          if (fl_q == 8'(FLASH_FRAMES - 1)) begin
            state_d = ST_OVER;
            flash_d = 1'b1;
          end else begin
            fl_d = fl_q + 8'd1;
            if (fl_q[1:0] == 2'b11) flash_d = ~flash_q;
          end
        end
      end
      ST_OVER: begin
        flash_d = 1'b1;
        if (restart_req) begin
          state_d = ST_IDLE;
          fc_d    = '0;
          fl_d    = '0;
          sec_d   = 4'd0;
          tens_d  = 4'd0;
          hund_d  = 4'd0;
          flash_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    char_en_d  = (state_d == ST_IDLE) || (state_d == ST_RUN);
    enemy_en_d = (state_d == ST_RUN);
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q    <= ST_IDLE;
      fc_q       <= '0;
      fl_q       <= '0;
      sec_q      <= 4'd0;
      tens_q     <= 4'd0;
      hund_q     <= 4'd0;
      flash_q    <= 1'b0;
      char_en_q  <= 1'b1;
      enemy_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fc_q       <= fc_d;
      fl_q       <= fl_d;
      sec_q      <= sec_d;
      tens_q     <= tens_d;
      hund_q     <= hund_d;
      flash_q    <= flash_d;
      char_en_q  <= char_en_d;
      enemy_en_q <= enemy_en_d;
    end
  end

  assign state      = state_q;
  assign char_en    = char_en_q;
  assign enemy_en   = enemy_en_q;
  assign flash_red  = flash_q;
  assign frame_tick = frame_tick_q;
  assign dig_sec    = sec_q;
  assign dig_tens   = tens_q;
  assign dig_hund   = hund_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios plus a random operation mix, all
// checked against a tick-counting model of the game rules.
module tb_game_flow_ctrl;
  // A short second keeps the saturation run small; all expectations scale with FPS.
  localparam int FPS = 3;
  localparam int FF  = 30;
  localparam int SS  = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       vsync = 1'b0, hit = 1'b0, move = 1'b0, restart = 1'b0;
  logic       char_en, enemy_en, flash_red, frame_tick;
  logic [1:0] state;
  logic [3:0] dig_sec, dig_tens, dig_hund;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: game state, ticks counted while running, ticks seen while flashing.
  int m_state = 0;
  int m_ticks = 0;
  int m_fl    = 0;

  game_flow_ctrl #(.FRAMES_PER_SEC(FPS), .FLASH_FRAMES(FF), .SYNC_STAGES(SS)) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rstn), .vsync_in(vsync), .hit_in(hit),
    .move_req(move), .restart_req(restart), .char_en(char_en), .enemy_en(enemy_en),
    .flash_red(flash_red), .state(state), .frame_tick(frame_tick),
    .dig_sec(dig_sec), .dig_tens(dig_tens), .dig_hund(dig_hund)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] model_vec();
    int   secs = m_ticks / FPS;
    logic fl;
    if (secs > 999) secs = 999;
    fl = (m_state == 3) || (m_state == 2 && ((m_fl / 4) % 2 == 0));
    return {2'(m_state), m_state < 2, m_state == 1, fl,
            4'(secs / 100), 4'((secs / 10) % 10), 4'(secs % 10)};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {state, char_en, enemy_en, flash_red, dig_hund, dig_tens, dig_sec};
  endfunction

  task automatic model_tick();
    if (m_state == 1) m_ticks++;
    else if (m_state == 2) begin
      if (m_fl == FF - 1) m_state = 3;
      else m_fl++;
    end
  endtask

  task automatic do_vsync(input int hi);
    vsync = 1'b1; step(hi);
    vsync = 1'b0; step(4);
    model_tick();
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b1; step(1);
      vsync = 1'b0; step(1);
      model_tick();
    end
    step(4);
  endtask

  task automatic do_move();
    move = 1'b1; step(1);
    move = 1'b0; step(1);
    if (m_state == 0) m_state = 1;
  endtask

  task automatic do_restart();
    restart = 1'b1; step(1);
    restart = 1'b0; step(1);
    if (m_state == 3) begin m_state = 0; m_ticks = 0; m_fl = 0; end
  endtask

  task automatic do_hit(input int hold);
    hit = 1'b1; step(hold);
    hit = 1'b0; step(SS + 1);
    if (m_state == 1) begin m_state = 2; m_fl = 0; end
  endtask

  task automatic test_reset();
    step(2);
    n_cmp++;
    if (dut_vec() !== model_vec() || frame_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: got %h ft=%b expected %h ft=0", dut_vec(), frame_tick, model_vec());
    end
    rstn = 1'b1; step(1);
  endtask

  task automatic test_frame_tick();
    logic [2:0] seen;
    vsync = 1'b1;
    step(SS);     seen[0] = frame_tick;
    step(1);      seen[1] = frame_tick;
    step(1);      seen[2] = frame_tick;
    vsync = 1'b0; step(4);
    n_cmp++;
    if (seen !== 3'b010) begin
      n_bad++;
      $display("FAIL frame_tick_timing: got %b expected 010", seen);
    end
    n_cmp++;
    if (dut_vec() !== model_vec()) begin
      n_bad++;
      $display("FAIL idle_ignores_tick: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_count();
    move = 1'b1; step(1);
    n_cmp++;
    if (state !== 2'd1 || enemy_en !== 1'b1) begin
      n_bad++;
      $display("FAIL move_to_run: got state=%0d en=%b expected state=1 en=1", state, enemy_en);
    end
    move = 1'b0; step(1);
    m_state = 1;
    for (int i = 1; i <= 125; i++) begin
      do_vsync($urandom_range(1, 3));
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL count_tick%0d: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_hit();
    logic [16:0] frozen;
    frozen = model_vec();
    hit = 1'b1; step(SS);
    n_cmp++;
    if (state !== 2'd1 || enemy_en !== 1'b1) begin
      n_bad++;
      $display("FAIL hit_early: got state=%0d en=%b expected state=1 en=1", state, enemy_en);
    end
    step(1);
    n_cmp++;
    if (state !== 2'd2 || enemy_en !== 1'b0 || char_en !== 1'b0 || flash_red !== 1'b1 ||
        {dig_hund, dig_tens, dig_sec} !== frozen[11:0]) begin
      n_bad++;
      $display("FAIL hit_latency: got %h expected state=2 en=0 ch=0 fl=1 digits %h",
               dut_vec(), frozen[11:0]);
    end
    hit = 1'b0; step(2);
    m_state = 2; m_fl = 0;
    for (int i = 1; i <= FF + 2; i++) begin
      do_vsync(1);
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL flash_tick%0d: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_ignore();
    do_hit(2);
    n_cmp++;
    if (dut_vec() !== model_vec()) begin
      n_bad++; $display("FAIL hit_in_over: got %h expected %h", dut_vec(), model_vec());
    end
    do_move();
    n_cmp++;
    if (dut_vec() !== model_vec()) begin
      n_bad++; $display("FAIL move_in_over: got %h expected %h", dut_vec(), model_vec());
    end
    do_restart();
    do_hit(1);
    n_cmp++;
    if (dut_vec() !== model_vec()) begin
      n_bad++; $display("FAIL hit_in_idle: got %h expected %h", dut_vec(), model_vec());
    end
    do_move();
    do_ticks(4);
    do_restart();
    n_cmp++;
    if (dut_vec() !== model_vec()) begin
      n_bad++; $display("FAIL restart_in_run: got %h expected %h", dut_vec(), model_vec());
    end
    do_hit(1);
    for (int i = 0; i < 6; i++) begin
      move = ~move; step(1);
      do_vsync(1);
      do_restart();
    end
    move = 1'b0; step(1);
    n_cmp++;
    if (dut_vec() !== model_vec()) begin
      n_bad++; $display("FAIL move_restart_in_flash: got %h expected %h", dut_vec(), model_vec());
    end
    do_ticks(FF);
  endtask

  task automatic test_simultaneous();
    restart = 1'b1; move = 1'b1; step(1);
    n_cmp++;
    if (state !== 2'd0 || {dig_hund, dig_tens, dig_sec} !== 12'h000) begin
      n_bad++;
      $display("FAIL over_restart_move_1: got state=%0d digits %h expected state=0 digits 000",
               state, {dig_hund, dig_tens, dig_sec});
    end
    restart = 1'b0; step(1);
    n_cmp++;
    if (state !== 2'd1) begin
      n_bad++; $display("FAIL over_restart_move_2: got state=%0d expected 1", state);
    end
    move = 1'b0; step(1);
    m_state = 1; m_ticks = 0; m_fl = 0;
    do_ticks(4 * FPS - 1);
    // Hit lands on the same edge that consumes the tick completing second 4.
    vsync = 1'b1; step(1);
    hit = 1'b1;   step(SS + 1);
    n_cmp++;
    if (state !== 2'd2 || dig_sec !== 4'd4) begin
      n_bad++;
      $display("FAIL hit_with_tick: got state=%0d sec=%0d expected state=2 sec=4", state, dig_sec);
    end
    vsync = 1'b0; hit = 1'b0; step(4);
    m_ticks++; m_state = 2; m_fl = 0;
    n_cmp++;
    if (dut_vec() !== model_vec()) begin
      n_bad++; $display("FAIL hit_with_tick_after: got %h expected %h", dut_vec(), model_vec());
    end
    do_ticks(FF);
  endtask

  task automatic test_carry_sat();
    int targets [6] = '{9 * FPS, 10 * FPS, 100 * FPS - 1, 100 * FPS, 999 * FPS, 999 * FPS + 20 * FPS};
    do_restart();
    do_move();
    foreach (targets[i]) begin
      do_ticks(targets[i] - m_ticks);
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL carry_at_%0d: got %h expected %h", targets[i], dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    rstn = 1'b0; step(1);
    rstn = 1'b1; step(1);
    m_state = 0; m_ticks = 0; m_fl = 0;
    do_move();
    do_ticks(12 * FPS);
    n_cmp++;
    if ({dig_hund, dig_tens, dig_sec} !== 12'h012) begin
      n_bad++; $display("FAIL preload_012: got %h expected 012", {dig_hund, dig_tens, dig_sec});
    end
    vsync = 1'b1; step(SS);
    rstn = 1'b0; #1;
    m_state = 0; m_ticks = 0; m_fl = 0;
    n_cmp++;
    if (dut_vec() !== model_vec() || frame_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got %h ft=%b expected %h ft=0", dut_vec(), frame_tick, model_vec());
    end
    vsync = 1'b0; step(2);
    rstn = 1'b1; step(4);
    n_cmp++;
    if (dut_vec() !== model_vec() || frame_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL after_reset: got %h ft=%b expected %h ft=0", dut_vec(), frame_tick, model_vec());
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 6)      do_vsync($urandom_range(1, 3));
      else if (r == 7) do_move();
      else if (r == 8) do_restart();
      else             do_hit($urandom_range(1, 3));
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL random_op%0d(kind %0d): got %h expected %h", i, r, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_tick();
    test_count();
    test_hit();
    test_ignore();
    test_simultaneous();
    test_carry_sat();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
